// File: rtl/text_console_pkg.sv
// Shared definitions for the Wishbone text console: register map, control codes,
// FSM state encoding and default screen geometry.
package text_console_pkg;

  localparam int unsigned DEFAULT_COLS = 80;
  localparam int unsigned DEFAULT_ROWS = 25;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_CUR_X  = 3'd2;
  localparam logic [2:0] REG_CUR_Y  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_MODE   = 3'd5;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StScrCopy,
    StScrFill
  } state_e;

  // y * cols as a shift-add over the bits of y; cols is a constant so this folds to adders.
  function automatic logic [15:0] mul_const(input logic [15:0] y, input int unsigned cols);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) acc = acc + (16'(cols) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/text_console_fill.sv
// Sequential address generator: after a start pulse, emits count_i consecutive
// addresses from start_addr_i, one per cycle, with done_o high on the last one.
// count_i must be at least 1.
module text_console_fill #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              active_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  logic              active_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;

  // Load on start, then step address up and remaining count down until exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      addr_q   <= start_addr_i;
      cnt_q    <= count_i - CNT_W'(1);
    end else if (active_q) begin
      addr_q <= addr_q + ADDR_W'(1);
      cnt_q  <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) active_q <= 1'b0;
    end
  end

  assign active_o = active_q;
  assign addr_o   = addr_q;
  assign done_o   = active_q && (cnt_q == '0);

endmodule

// File: rtl/wb_text_console.sv
// Wishbone text console: cursor tracking, CR/LF/BS handling, glyph writes to the
// character RAM, hardware clear and (with TEXT_CONSOLE_AUTOSCROLL_EN) scroll-up.
module wb_text_console
  import text_console_pkg::*;
#(
  parameter int unsigned COLS      = DEFAULT_COLS,
  parameter int unsigned ROWS      = DEFAULT_ROWS,
  parameter int unsigned ADDR_W    = 11,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_adr_i,
  input  logic [7:0]        wb_dat_i,
  output logic [7:0]        wb_dat_o,
  output logic              wb_ack_o,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        pattern_mode,
  output logic              busy
);

  localparam int unsigned XW    = $clog2(COLS);
  localparam int unsigned YW    = $clog2(ROWS);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [XW-1:0]     X_MAX      = XW'(COLS - 1);
  localparam logic [YW-1:0]     Y_MAX      = YW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_A = ADDR_W'(COLS * (ROWS - 1));

  state_e            state_q, state_d;
  logic [XW-1:0]     cur_x_q, cur_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              ack_q;
  logic [7:0]        dat_q, dat_d;
  logic [1:0]        mode_q, mode_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic              accept, newline;
  logic              fill_start, fill_active, fill_done;
  logic [ADDR_W-1:0] fill_start_addr, fill_addr;
  logic [CNT_W-1:0]  fill_count;

`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_COPY_A = ADDR_W'(COLS * (ROWS - 1) - 1);
  logic [ADDR_W-1:0] copy_a_q, copy_a_d;
  logic              phase_q, phase_d;  // 0: read source row, 1: write destination
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  assign busy = (state_q != StIdle);

  // Writes to DATA/CTRL stall while the engine is busy; nothing is taken while ack is high.
  assign accept = wb_cyc_i && wb_stb_i && !ack_q &&
                  !(wb_we_i && (wb_adr_i[2:1] == 2'b00) && busy);

  text_console_fill #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_fill (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (fill_start),
    .start_addr_i(fill_start_addr),
    .count_i     (fill_count),
    .active_o    (fill_active),
    .addr_o      (fill_addr),
    .done_o      (fill_done)
  );

  // Register-file decode, character interpretation and FSM next state.
  always_comb begin
    state_d         = state_q;
    cur_x_d         = cur_x_q;
    cur_y_d         = cur_y_q;
    row_base_d      = row_base_q;
    dat_d           = dat_q;
    mode_d          = mode_q;
    wr_d            = 1'b0;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    newline         = 1'b0;
    fill_start      = 1'b0;
    fill_start_addr = '0;
    fill_count      = '0;
`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
    copy_a_d = copy_a_q;
    phase_d  = phase_q;
`endif

    if (state_q == StIdle) addr_d = row_base_q + ADDR_W'(cur_x_q);

    if (accept && wb_we_i) begin
      case (wb_adr_i)
        REG_DATA: begin
          case (wb_dat_i)
            CH_CR: cur_x_d = '0;
            CH_LF: begin
              cur_x_d = '0;
              newline = 1'b1;
            end
            CH_BS: if (cur_x_q != '0) cur_x_d = cur_x_q - XW'(1);
            default: begin
              wr_d    = 1'b1;
              wdata_d = wb_dat_i;
              if (cur_x_q == X_MAX) begin
                cur_x_d = '0;
                newline = 1'b1;
              end else begin
                cur_x_d = cur_x_q + XW'(1);
              end
            end
          endcase
          if (newline) begin
            if (cur_y_q != Y_MAX) begin
              cur_y_d    = cur_y_q + YW'(1);
              row_base_d = row_base_q + ADDR_W'(COLS);
            end else begin
`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
              state_d  = StScrCopy;
              copy_a_d = '0;
              phase_d  = 1'b0;
`else
              cur_y_d    = '0;
              row_base_d = '0;
`endif
            end
          end
        end
        REG_CTRL: begin
          if (wb_dat_i[0]) begin
            state_d         = StClear;
            fill_start      = 1'b1;
            fill_start_addr = '0;
            fill_count      = CNT_W'(COLS * ROWS);
          end
        end
        REG_CUR_X: cur_x_d = (wb_dat_i >= 8'(COLS - 1)) ? X_MAX : XW'(wb_dat_i);
        REG_CUR_Y: begin
          cur_y_d    = (wb_dat_i >= 8'(ROWS - 1)) ? Y_MAX : YW'(wb_dat_i);
          row_base_d = ADDR_W'(mul_const(16'(cur_y_d), COLS));
        end
        REG_MODE: mode_d = wb_dat_i[1:0];
        default: ;
      endcase
    end else if (accept) begin
      case (wb_adr_i)
        REG_CUR_X:  dat_d = 8'(cur_x_q);
        REG_CUR_Y:  dat_d = 8'(cur_y_q);
        REG_STATUS: dat_d = {7'd0, busy};
        REG_MODE:   dat_d = {6'd0, mode_q};
        default:    dat_d = 8'h00;
      endcase
    end

    case (state_q)
      StIdle: ;
      StClear: begin
        if (fill_done) begin
          state_d    = StIdle;
          cur_x_d    = '0;
          cur_y_d    = '0;
          row_base_d = '0;
        end
      end
`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
      StScrCopy: begin
        // Hold off while the glyph that caused the wrap is still being written.
        if (!wr_q) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            if (copy_a_q == LAST_COPY_A) begin
              state_d         = StScrFill;
              fill_start      = 1'b1;
              fill_start_addr = LAST_ROW_A;
              fill_count      = CNT_W'(COLS);
            end else begin
              copy_a_d = copy_a_q + ADDR_W'(1);
            end
          end
        end
      end
      StScrFill: begin
        if (fill_done) begin
          state_d    = StIdle;
          cur_x_d    = '0;
          cur_y_d    = Y_MAX;
          row_base_d = LAST_ROW_A;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      mode_q     <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
      copy_a_q <= '0;
      phase_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      ack_q      <= accept;
      dat_q      <= dat_d;
      mode_q     <= mode_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
      copy_a_q <= copy_a_d;
      phase_q  <= phase_d;
`endif
    end
  end

  // RAM port mux: a pending glyph write wins, otherwise the active engine drives it.
  always_comb begin
    ram_we    = wr_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (!wr_q) begin
      case (state_q)
        StClear, StScrFill: begin
          ram_we    = fill_active;
          ram_addr  = fill_addr;
          ram_wdata = FILL_CHAR;
        end
`ifdef TEXT_CONSOLE_AUTOSCROLL_EN
        StScrCopy: begin
          ram_we    = phase_q;
          ram_addr  = phase_q ? copy_a_q : copy_a_q + COLS_A;
          ram_wdata = ram_rdata;
        end
`endif
        default: ;
      endcase
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign pattern_mode = mode_q;

endmodule
